// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - CPU request, loader and RAM signal bundle for mem_access_ctrl
interface mem_access_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
);
    logic                  cpu_read;
    logic                  cpu_write;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_done;
    logic                  cpu_busy;
    logic                  cpu_err;
    logic                  overrun;
    logic                  ld_valid;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  ld_ready;
    logic                  ram_enable;
    logic                  ram_read;
    logic                  ram_write;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;

    modport slave (
        input  cpu_read, cpu_write, cpu_addr, cpu_wdata,
        input  ld_valid, ld_addr, ld_data, ram_rdata,
        output cpu_rdata, cpu_done, cpu_busy, cpu_err, overrun, ld_ready,
        output ram_enable, ram_read, ram_write, ram_addr, ram_wdata
    );

    modport master (
        output cpu_read, cpu_write, cpu_addr, cpu_wdata,
        output ld_valid, ld_addr, ld_data, ram_rdata,
        input  cpu_rdata, cpu_done, cpu_busy, cpu_err, overrun, ld_ready,
        input  ram_enable, ram_read, ram_write, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - sequenced RAM access controller with loader priority and one-entry pending slot
// Optional address bounds checking enabled by defining MEM_BOUNDS_CHECK_EN.
module mem_access_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int RD_LATENCY = 1,
    parameter int MEM_DEPTH  = 512
) (
    input  logic               clock,
    input  logic               clear,
    mem_access_ctrl_if.slave   bus
);

    localparam int LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LATENCY - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(MEM_DEPTH);
`ifdef MEM_BOUNDS_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, LOAD, READ, WRITE, RESP} state_t;

    state_t state, state_nxt;

    logic                  intake_valid, intake_read;
    logic [ADDR_WIDTH-1:0] intake_addr;
    logic [DATA_WIDTH-1:0] intake_wdata;

    logic                  slot_full, slot_read;
    logic [ADDR_WIDTH-1:0] slot_addr;
    logic [DATA_WIDTH-1:0] slot_wdata;

    logic                  act_err;
    logic [ADDR_WIDTH-1:0] act_addr;
    logic [DATA_WIDTH-1:0] act_wdata;

    logic [LAT_W-1:0]      lat_cnt;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  overrun_q;
    logic                  ram_en_q, ram_rd_q, ram_wr_q;

    logic                  take_ld, take_slot, take_intake, to_slot, drop, capture;
    logic                  en_nxt, rd_nxt, wr_nxt;
    logic                  sel_read, sel_err, ld_err;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
        return CHECK_EN && ({1'b0, a} >= DEPTH_LIM);
    endfunction

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The pending slot, when full, is older than the intake register and is served first.
    always_comb begin
        state_nxt   = state;
        take_ld     = 1'b0;
        take_slot   = 1'b0;
        take_intake = 1'b0;
        capture     = 1'b0;
        en_nxt      = 1'b0;
        rd_nxt      = 1'b0;
        wr_nxt      = 1'b0;
        sel_read    = slot_full ? slot_read  : intake_read;
        sel_addr    = slot_full ? slot_addr  : intake_addr;
        sel_wdata   = slot_full ? slot_wdata : intake_wdata;
        sel_err     = out_of_range(sel_addr);
        ld_err      = out_of_range(bus.ld_addr);
        case (state)
            IDLE: begin
                if (bus.ld_valid) begin
                    take_ld   = 1'b1;
                    state_nxt = LOAD;
                    en_nxt    = !ld_err;
                    wr_nxt    = !ld_err;
                end else if (slot_full || intake_valid) begin
                    take_slot   = slot_full;
                    take_intake = !slot_full;
                    if (sel_err) begin
                        state_nxt = RESP;
                    end else if (sel_read) begin
                        state_nxt = READ;
                        en_nxt    = 1'b1;
                        rd_nxt    = 1'b1;
                    end else begin
                        state_nxt = WRITE;
                        en_nxt    = 1'b1;
                        wr_nxt    = 1'b1;
                    end
                end
            end
            LOAD:  state_nxt = IDLE;
            READ: begin
                if (lat_cnt == LAT_LAST) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end else begin
                    en_nxt = 1'b1;
                    rd_nxt = 1'b1;
                end
            end
            WRITE: state_nxt = RESP;
            RESP:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        to_slot = intake_valid && !take_intake && (!slot_full || take_slot);
        drop    = intake_valid && !take_intake && slot_full && !take_slot;
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            intake_valid <= 1'b0;
            intake_read  <= 1'b0;
            intake_addr  <= '0;
            intake_wdata <= '0;
            slot_full    <= 1'b0;
            slot_read    <= 1'b0;
            slot_addr    <= '0;
            slot_wdata   <= '0;
            act_err      <= 1'b0;
            act_addr     <= '0;
            act_wdata    <= '0;
            lat_cnt      <= '0;
            rdata_q      <= '0;
            overrun_q    <= 1'b0;
            ram_en_q     <= 1'b0;
            ram_rd_q     <= 1'b0;
            ram_wr_q     <= 1'b0;
        end else begin
            // A simultaneous read and write strobe is taken as a read.
            intake_valid <= bus.cpu_read || bus.cpu_write;
            intake_read  <= bus.cpu_read;
            if (bus.cpu_read || bus.cpu_write) begin
                intake_addr  <= bus.cpu_addr;
                intake_wdata <= bus.cpu_wdata;
            end

            if (take_slot) begin
                slot_full <= 1'b0;
            end
            if (to_slot) begin
                slot_full  <= 1'b1;
                slot_read  <= intake_read;
                slot_addr  <= intake_addr;
                slot_wdata <= intake_wdata;
            end

            if (take_ld) begin
                act_addr  <= bus.ld_addr;
                act_wdata <= bus.ld_data;
                act_err   <= ld_err;
            end else if (take_slot || take_intake) begin
                act_addr  <= sel_addr;
                act_wdata <= sel_wdata;
                act_err   <= sel_err;
                if (sel_err && sel_read) begin
                    rdata_q <= '0;
                end
            end

            if (capture) begin
                rdata_q <= bus.ram_rdata;
            end
            lat_cnt <= (state == READ && !capture) ? lat_cnt + 1'b1 : '0;

            if (drop) begin
                overrun_q <= 1'b1;
            end

            ram_en_q <= en_nxt;
            ram_rd_q <= rd_nxt;
            ram_wr_q <= wr_nxt;
        end
    end

    assign bus.cpu_rdata  = rdata_q;
    assign bus.cpu_done   = (state == RESP);
    assign bus.cpu_err    = (state == RESP) && act_err;
    assign bus.cpu_busy   = (state != IDLE) || slot_full;
    assign bus.overrun    = overrun_q;
    assign bus.ld_ready   = (state == IDLE) && !clear;
    assign bus.ram_enable = ram_en_q;
    assign bus.ram_read   = ram_rd_q;
    assign bus.ram_write  = ram_wr_q;
    assign bus.ram_addr   = act_addr;
    assign bus.ram_wdata  = act_wdata;

endmodule
